fp_add_norm_round: RTL and testbench
====================================

// Module: fp_add_norm_round
// PURPOSE
//  Final stage of the pipelined FP adder. Sits downstream of the add/normalise pipeline register.
//  Takes the raw 28-bit sum fraction, 10-bit biased exponent, rounding mode, sign and inf/NaN bypass.
//  Two internal stages: S1 normalises (LZC, shift, exponent adjust); S2 rounds, handles
//  overflow/underflow/special cases and holds the IEEE-754 single result.
//  Valid/ready handshake on both sides; full throughput, latency 2.
// PARAMETERS
//  FRAC_W   28  input fraction width: [27]=carry-out, [26]=hidden, [25:3]=fraction, [2:0]=G,R,S
//  EXP_W    10  input exponent width (biased, two's complement; negative values allowed)
// PORTS
//  clock           in   1   pipeline clock, rising edge
//  clrn            in   1   asynchronous reset, active low
//  flush           in   1   synchronous clear of all stage valids (pipeline kill)
//  in_valid        in   1   input bundle valid
//  in_ready        out  1   stage can accept the bundle this cycle
//  n_rm            in   2   rounding mode: 00 RNE, 01 toward -inf, 10 toward +inf, 11 toward zero
//  n_sign          in   1   result sign
//  n_exp10         in   10  biased exponent of n_frac (bias 127, value when hidden bit is at [26])
//  n_is_inf_nan    in   1   result is inf or NaN; bypasses arithmetic
//  n_inf_nan_frac  in   23  fraction to emit when n_is_inf_nan (0 = inf, else NaN payload)
//  n_frac          in   28  unnormalised sum fraction
//  out_valid       out  1   s / flags valid
//  out_ready       in   1   consumer accepts the result this cycle
//  s               out  32  IEEE-754 single result
//  flags           out  4   {overflow, underflow, inexact, zero}
// BEHAVIOUR
//  Reset (clrn=0, async): s1_valid=0, out_valid=0, s=0, flags=0, all internal regs 0.
//  Reset has priority over flush; flush has priority over capture. Reset mid-operation discards all in-flight bundles.
//  Handshake:
//   - Transfer occurs on in_valid&in_ready and on out_valid&out_ready.
//   - S2 loads when !out_valid | out_ready.
//   - S1 loads when !s1_valid | S2 loads. in_ready = !s1_valid | S2 loads (combinational from out_ready).
//   - Stalled stages hold all fields unchanged. Capacity 2 bundles. Latency 2 cycles, 1/clk throughput.
//  S1 normalise:
//   - n_frac[27]=1: shift right 1; new S = n_frac[1]|n_frac[0]; exp+1.
//   - Else lz = leading zeros of n_frac[26:0] (0..27).
//     - n_frac[26:0]==0: exact zero.
//     - Otherwise sh = (exp>lz) ? lz : max(exp-1,0); shift left sh; exp -= sh.
//     - Hidden bit still 0 after the shift: denormal, exp field = 0.
//   - Input exp<=0 and no carry: shift right (1-exp), saturate at 27.
//     Shifted-out bits OR into S; exp field 0.
//  S2 round:
//   - Round-up condition, with L=frac LSB and G,R,S below it:
//     - RNE: G&(R|S|L)
//     - -inf: sign&(G|R|S)
//     - +inf: !sign&(G|R|S)
//     - toward zero: never
//   - Mantissa increment carries into the hidden bit: exp+1, fraction 0.
//   - Denormal rounding up to 1.0 sets exp field 1.
//   - exp>=255 after rounding: overflow.
//     - RNE, or directed mode toward the sign: s={sign,8'hFF,0}.
//     - Otherwise s={sign,8'hFE,23'h7FFFFF}.
//     - flags overflow=1, inexact=1.
//   - inexact = G|R|S.
//   - underflow = inexact & result denormal or zero.
//   - zero = (s[30:0]==0).
//   - Exact zero: s={n_sign,31'b0} (sign decided upstream).
//   - n_is_inf_nan: s={n_sign,8'hFF,n_inf_nan_frac}, flags=0. Overrides all arithmetic.
// TESTING
//  1.0+1.0: n_frac=28'h8000000, exp=127, rm=00 -> s=32'h40000000 two cycles later, flags=0.
//  Cancellation: n_frac=28'h0000008, exp=127 -> s=32'h34000000, flags=0.
//  Tie, odd LSB: n_frac=28'h400000C, exp=127, rm=00 -> s=32'h3F800002, inexact=1.
//   Same input with rm=11 -> s=32'h3F800001.
//  Overflow: n_frac=28'h8000000, exp=254:
//   - rm=00 -> 32'h7F800000, flags=4'b1010.
//   - rm=11 -> 32'h7F7FFFFF, flags=4'b1010.
//  Backpressure: 3 back-to-back inputs with out_ready=0 -> in_ready=0 once 2 are held.
//   Release out_ready -> results emerge in order, none dropped or duplicated.
//  NaN pass-through (n_is_inf_nan=1, frac=23'h400000) -> 32'h7FC00000 or 32'hFFC00000 by sign.
//   clrn pulse mid-stream -> out_valid=0 immediately.
//   flush with 2 in flight -> nothing emitted.

Source files
------------

// File: rtl/fp_add_norm_round_if.sv
// fp_add_norm_round_if: handshake bundle for the FP adder normalise/round stage.
//   in side : in_valid/in_ready plus n_rm, n_sign, n_exp10, n_is_inf_nan, n_inf_nan_frac, n_frac
//   out side: out_valid/out_ready plus s (IEEE-754 single) and flags {ovf, unf, inexact, zero}
//   master = producer of inputs / consumer of results, slave = the stage itself
interface fp_add_norm_round_if #(
    parameter int FRAC_W = 28,
    parameter int EXP_W  = 10
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        n_rm;
    logic              n_sign;
    logic [EXP_W-1:0]  n_exp10;
    logic              n_is_inf_nan;
    logic [22:0]       n_inf_nan_frac;
    logic [FRAC_W-1:0] n_frac;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       s;
    logic [3:0]        flags;
    modport master (
        output in_valid, n_rm, n_sign, n_exp10, n_is_inf_nan, n_inf_nan_frac, n_frac, out_ready,
        input  in_ready, out_valid, s, flags
    );
    modport slave (
        input  in_valid, n_rm, n_sign, n_exp10, n_is_inf_nan, n_inf_nan_frac, n_frac, out_ready,
        output in_ready, out_valid, s, flags
    );
endinterface

// File: rtl/fp_add_norm_round.sv
// fp_add_norm_round: final FP adder stage; S1 normalises the raw sum, S2 rounds and packs.
//   clock : pipeline clock, rising edge
//   clrn  : asynchronous reset, active low
//   flush : synchronous kill of both stage valids
//   bus   : slave side of fp_add_norm_round_if (valid/ready in, valid/ready out, s, flags)
module fp_add_norm_round #(
    parameter int FRAC_W = 28,
    parameter int EXP_W  = 10
) (
    input  logic               clock,
    input  logic               clrn,
    input  logic               flush,
    fp_add_norm_round_if.slave bus
);
    localparam int MW = FRAC_W - 1;
    localparam int EW = EXP_W + 1;
    typedef struct packed {
        logic [1:0]    rm;
        logic          sign;
        logic          inf_nan;
        logic [22:0]   nan_frac;
        logic          zero;
        logic [MW-1:0] frac;
        logic [EW-1:0] exp;
    } s1_t;
    s1_t           s1_n, s1_d, s1_q;
    logic          s1_valid_d, s1_valid_q, out_valid_d, out_valid_q;
    logic [31:0]   res_s, s_d, s_q;
    logic [3:0]    res_flags, flags_d, flags_q;
    logic          s1_load, s2_load;
    logic [MW-1:0] low, rsh_frac;
    int            ei, lz, sh, er;
    logic [23:0]   mant;
    logic [24:0]   mant_r;
    logic          grs, up, to_inf;

    assign s2_load      = !out_valid_q || bus.out_ready;
    assign s1_load      = !s1_valid_q || s2_load;
    assign bus.in_ready = s1_load;
    assign bus.out_valid = out_valid_q;
    assign bus.s        = s_q;
    assign bus.flags    = flags_q;

    // S1: carry right-shift, LZC left-shift clamped to exp 1, or right-shift into the denormal range
    always_comb begin
        low = bus.n_frac[MW-1:0];
        ei  = int'($signed(bus.n_exp10));
        lz  = MW;
        for (int i = 0; i < MW; i++)
            if (low[i]) lz = MW - 1 - i;
        sh            = 0;
        rsh_frac      = '0;
        s1_n.rm       = bus.n_rm;
        s1_n.sign     = bus.n_sign;
        s1_n.inf_nan  = bus.n_is_inf_nan;
        s1_n.nan_frac = bus.n_inf_nan_frac;
        s1_n.zero     = 1'b0;
        s1_n.frac     = '0;
        s1_n.exp      = '0;
        if (bus.n_frac[MW]) begin
            s1_n.frac = {bus.n_frac[MW:2], |bus.n_frac[1:0]};
            s1_n.exp  = EW'(ei + 1);
        end else if (low == '0) begin
            s1_n.zero = 1'b1;
        end else if (ei <= 0) begin
            sh        = (1 - ei > MW) ? MW : 1 - ei;
            rsh_frac  = low >> sh;
            s1_n.frac = {rsh_frac[MW-1:1], rsh_frac[0] | (|(low & ~({MW{1'b1}} << sh)))};
        end else begin
            sh        = (ei > lz) ? lz : ei - 1;
            s1_n.frac = low << sh;
            // hidden bit still clear means the clamp left a denormal
            s1_n.exp  = s1_n.frac[MW-1] ? EW'(ei - sh) : '0;
        end
        s1_d       = s1_load ? s1_n : s1_q;
        s1_valid_d = !flush && (s1_load ? bus.in_valid : s1_valid_q);
    end

    // S2: round, then special cases in priority inf/NaN > zero > overflow
    always_comb begin
        mant   = s1_q.frac[MW-1:3];
        grs    = |s1_q.frac[2:0];
        up     = (s1_q.rm == 2'd0) ? s1_q.frac[2] & (s1_q.frac[1] | s1_q.frac[0] | s1_q.frac[3]) :
                 (s1_q.rm == 2'd1) ? s1_q.sign & grs :
                 (s1_q.rm == 2'd2) ? !s1_q.sign & grs : 1'b0;
        mant_r = {1'b0, mant} + 25'(up);
        // a denormal promotes when the carry reaches the hidden bit, a normal when it passes it
        er     = int'($signed(s1_q.exp)) + int'(s1_q.exp == '0 ? mant_r[23] : mant_r[24]);
        to_inf = (s1_q.rm == 2'd0) || (s1_q.rm == 2'd1 && s1_q.sign) || (s1_q.rm == 2'd2 && !s1_q.sign);
        res_s     = {s1_q.sign, 8'(er), mant_r[22:0]};
        res_flags = {1'b0, grs && er == 0, grs, res_s[30:0] == '0};
        if (s1_q.inf_nan) begin
            res_s     = {s1_q.sign, 8'hFF, s1_q.nan_frac};
            res_flags = 4'b0000;
        end else if (s1_q.zero) begin
            res_s     = {s1_q.sign, 31'b0};
            res_flags = 4'b0001;
        end else if (er >= 255) begin
            res_s     = to_inf ? {s1_q.sign, 8'hFF, 23'h0} : {s1_q.sign, 8'hFE, 23'h7FFFFF};
            res_flags = 4'b1010;
        end
        s_d         = s2_load ? res_s : s_q;
        flags_d     = s2_load ? res_flags : flags_q;
        out_valid_d = !flush && (s2_load ? s1_valid_q : out_valid_q);
    end

    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            s1_q        <= '0;
            s_q         <= '0;
            flags_q     <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            s1_q        <= s1_d;
            s_q         <= s_d;
            flags_q     <= flags_d;
        end
    end
endmodule

// File: tb/tb_fp_add_norm_round.sv
// tb_fp_add_norm_round: directed vectors with hand-computed results for fp_add_norm_round.
module tb_fp_add_norm_round;
    typedef struct packed {
        logic [1:0]  rm;
        logic        sign;
        logic [9:0]  e;
        logic        inf;
        logic [22:0] nf;
        logic [27:0] f;
        logic [31:0] s;
        logic [3:0]  fl;
    } vec_t;

    logic  clock = 1'b0;
    logic  clrn  = 1'b0;
    logic  flush = 1'b0;
    int    n_checks = 0;
    int    n_fails  = 0;
    vec_t  vq[$];
    logic [31:0] got[$];

    fp_add_norm_round_if bus ();
    fp_add_norm_round dut (.clock(clock), .clrn(clrn), .flush(flush), .bus(bus));

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, act, req);
        end
    endtask

    task automatic add(input logic [1:0] rm, input logic sign, input logic [9:0] e, input logic inf,
                       input logic [22:0] nf, input logic [27:0] f, input logic [31:0] s, input logic [3:0] fl);
        vq.push_back('{rm: rm, sign: sign, e: e, inf: inf, nf: nf, f: f, s: s, fl: fl});
    endtask

    task automatic drive(input vec_t v);
        bus.n_rm           = v.rm;
        bus.n_sign         = v.sign;
        bus.n_exp10        = v.e;
        bus.n_is_inf_nan   = v.inf;
        bus.n_inf_nan_frac = v.nf;
        bus.n_frac         = v.f;
        bus.in_valid       = 1'b1;
    endtask

    task automatic run_vec(input int idx);
        @(negedge clock);
        drive(vq[idx]);
        @(negedge clock);
        bus.in_valid = 1'b0;
        check_eq($sformatf("vec%0d latency", idx), 32'(bus.out_valid), 32'd0);
        @(negedge clock);
        check_eq($sformatf("vec%0d valid", idx), 32'(bus.out_valid), 32'd1);
        check_eq($sformatf("vec%0d s", idx), bus.s, vq[idx].s);
        check_eq($sformatf("vec%0d flags", idx), 32'(bus.flags), 32'(vq[idx].fl));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  emitted;
        logic accepted;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.n_rm = '0; bus.n_sign = 1'b0;
        bus.n_exp10 = '0; bus.n_is_inf_nan = 1'b0; bus.n_inf_nan_frac = '0; bus.n_frac = '0;
        add(2'd0, 1'b0, 10'd127, 1'b0, 23'h0, 28'h8000000, 32'h40000000, 4'b0000);
        add(2'd0, 1'b0, 10'd127, 1'b0, 23'h0, 28'h0000008, 32'h34000000, 4'b0000);
        add(2'd0, 1'b0, 10'd127, 1'b0, 23'h0, 28'h400000C, 32'h3F800002, 4'b0010);
        add(2'd3, 1'b0, 10'd127, 1'b0, 23'h0, 28'h400000C, 32'h3F800001, 4'b0010);
        add(2'd0, 1'b0, 10'd254, 1'b0, 23'h0, 28'h8000000, 32'h7F800000, 4'b1010);
        add(2'd3, 1'b0, 10'd254, 1'b0, 23'h0, 28'h8000000, 32'h7F7FFFFF, 4'b1010);
        add(2'd1, 1'b0, 10'd254, 1'b0, 23'h0, 28'h8000000, 32'h7F7FFFFF, 4'b1010);
        add(2'd2, 1'b0, 10'd254, 1'b0, 23'h0, 28'h8000000, 32'h7F800000, 4'b1010);
        add(2'd0, 1'b0, 10'd127, 1'b0, 23'h0, 28'h7FFFFFC, 32'h40000000, 4'b0010);
        add(2'd2, 1'b0, 10'd127, 1'b0, 23'h0, 28'h4000004, 32'h3F800001, 4'b0010);
        add(2'd0, 1'b0, 10'd127, 1'b0, 23'h0, 28'h4000004, 32'h3F800000, 4'b0010);
        add(2'd1, 1'b1, 10'd127, 1'b0, 23'h0, 28'h4000004, 32'hBF800001, 4'b0010);
        add(2'd0, 1'b0, 10'd0,   1'b0, 23'h0, 28'h4000008, 32'h00400000, 4'b0110);
        add(2'd0, 1'b0, 10'd5,   1'b0, 23'h0, 28'h0000008, 32'h00000010, 4'b0000);
        add(2'd0, 1'b1, 10'd127, 1'b0, 23'h0, 28'h0000000, 32'h80000000, 4'b0001);
        add(2'd0, 1'b0, 10'd127, 1'b1, 23'h400000, 28'h8000000, 32'h7FC00000, 4'b0000);
        add(2'd0, 1'b1, 10'd127, 1'b1, 23'h400000, 28'h8000000, 32'hFFC00000, 4'b0000);
        add(2'd0, 1'b0, 10'd254, 1'b1, 23'h0, 28'h8000000, 32'h7F800000, 4'b0000);
        add(2'd0, 1'b0, 10'h3FD, 1'b0, 23'h0, 28'h4000000, 32'h00080000, 4'b0000);

        #12;
        check_eq("reset out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("reset s", bus.s, 32'd0);
        check_eq("reset flags", 32'(bus.flags), 32'd0);
        check_eq("reset in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clock);
        clrn = 1'b1;

        for (int i = 0; i < vq.size(); i++) run_vec(i);

        // backpressure: three back-to-back inputs against a stalled consumer
        @(negedge clock);
        bus.out_ready = 1'b0;
        drive(vq[0]);
        @(negedge clock);
        drive(vq[1]);
        @(negedge clock);
        drive(vq[2]);
        #1;
        check_eq("bp in_ready full", 32'(bus.in_ready), 32'd0);
        repeat (3) @(negedge clock);
        #1;
        check_eq("bp in_ready held", 32'(bus.in_ready), 32'd0);
        check_eq("bp head held", bus.s, 32'h40000000);
        bus.out_ready = 1'b1;
        #1;
        accepted = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (bus.out_valid) got.push_back(bus.s);
            if (bus.in_valid && bus.in_ready) accepted = 1'b1;
            @(negedge clock);
            if (accepted) bus.in_valid = 1'b0;
            #1;
        end
        check_eq("bp count", 32'(got.size()), 32'd3);
        check_eq("bp order0", got[0], 32'h40000000);
        check_eq("bp order1", got[1], 32'h34000000);
        check_eq("bp order2", got[2], 32'h3F800002);

        // asynchronous reset with a result held at the output
        @(negedge clock);
        bus.out_ready = 1'b0;
        drive(vq[2]);
        @(negedge clock);
        bus.in_valid = 1'b0;
        @(negedge clock);
        check_eq("rst pre valid", 32'(bus.out_valid), 32'd1);
        #2 clrn = 1'b0;
        #1;
        check_eq("rst mid valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst mid s", bus.s, 32'd0);
        check_eq("rst mid in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clock);
        clrn = 1'b1;

        // flush with two bundles in flight
        @(negedge clock);
        drive(vq[0]);
        @(negedge clock);
        drive(vq[1]);
        @(negedge clock);
        bus.in_valid = 1'b0;
        check_eq("flush pre valid", 32'(bus.out_valid), 32'd1);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        bus.out_ready = 1'b1;
        emitted = 0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (bus.out_valid) emitted++;
            @(negedge clock);
        end
        check_eq("flush emitted", 32'(emitted), 32'd0);

        run_vec(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
